spi_sram_slave: RTL and testbench

SPI-slave bridge that emulates a serial SRAM (23LC-style READ/WRITE, 24-bit address, sequential mode) and converts each transaction into byte accesses on a simple synchronous parallel memory port. It sits between an external SPI master and an on-chip byte-wide RAM. The SPI clock is the system clock: the master changes MOSI on falling `clk` edges, and the block samples MOSI on rising `clk` edges where `en` is high.

---
 rtl/spi_sram_slave.sv | 185 ++++++++++++++++++
 tb/tb_spi_sram_slave.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_sram_slave.sv
// SPI slave emulating a 23LC-style serial SRAM (READ/WRITE, 24-bit address,
// sequential mode), bridged onto a byte-wide synchronous memory port.
module spi_sram_slave (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic [23:0] mem_addr,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    READ,
    WRITE,
    IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic        rd_q, rd_d;
  logic [7:0]  sr_q, sr_d;
  logic [7:0]  osr_q, osr_d;
  logic [23:0] addr_q, addr_d;
  logic        miso_q, miso_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_wr_q, mem_wr_d;
  logic [23:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;

  logic [7:0]  sr_next;
  logic [23:0] addr_next;
  logic [4:0]  cnt_wrap;

  assign sr_next   = {sr_q[6:0], mosi};
  assign addr_next = {addr_q[22:0], mosi};
  assign cnt_wrap  = (cnt_q == 5'd7) ? '0 : cnt_q + 5'd1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    armed_d     = armed_q;
    rd_d        = rd_q;
    sr_d        = sr_q;
    osr_d       = osr_q;
    addr_d      = addr_q;
    miso_d      = miso_q;
    mem_en_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    if (en) begin
      if (cs_n) begin
        state_d = IDLE;
        cnt_d   = '0;
        miso_d  = 1'b0;
        osr_d   = '0;
        armed_d = 1'b1;
      end else begin
        unique case (state_q)
          // a transaction may only start once cs_n has been seen high
          IDLE: begin
            if (armed_q) begin
              sr_d    = sr_next;
              cnt_d   = 5'd1;
              state_d = CMD;
            end
          end
          CMD: begin
            sr_d  = sr_next;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d = '0;
              if (sr_next[6:0] == 7'h03) begin
                state_d = ADDR;
                rd_d    = 1'b1;
              end else if (sr_next[6:0] == 7'h02) begin
                state_d = ADDR;
                rd_d    = 1'b0;
              end else begin
                state_d = IGNORE;
              end
            end
          end
          ADDR: begin
            addr_d = addr_next;
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'd23) begin
              cnt_d  = '0;
              osr_d  = '0;
              miso_d = 1'b0;
              if (rd_q) begin
                state_d    = READ;
                mem_en_d   = 1'b1;
                mem_addr_d = addr_next;
                addr_d     = addr_next + 24'd1;
              end else begin
                state_d = WRITE;
              end
            end
          end
          // slot 1 loads the fetched byte, slot 7 prefetches the next one
          READ: begin
            cnt_d = cnt_wrap;
            if (cnt_q == 5'd1) begin
              miso_d = mem_rdata[7];
              osr_d  = {mem_rdata[6:0], 1'b0};
            end else begin
              miso_d = osr_q[7];
              osr_d  = {osr_q[6:0], 1'b0};
            end
            if (cnt_q == 5'd7) begin
              mem_en_d   = 1'b1;
              mem_addr_d = addr_q;
              addr_d     = addr_q + 24'd1;
            end
          end
          WRITE: begin
            sr_d  = sr_next;
            cnt_d = cnt_wrap;
            if (cnt_q == 5'd7) begin
              mem_en_d    = 1'b1;
              mem_wr_d    = 1'b1;
              mem_wdata_d = sr_next;
              mem_addr_d  = addr_q;
              addr_d      = addr_q + 24'd1;
            end
          end
          IGNORE: begin
            miso_d = 1'b0;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      rd_q        <= 1'b0;
      sr_q        <= '0;
      osr_q       <= '0;
      addr_q      <= '0;
      miso_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      rd_q        <= rd_d;
      sr_q        <= sr_d;
      osr_q       <= osr_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign miso      = miso_q;
  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_spi_sram_slave.sv
// Randomized bench for spi_sram_slave: per-transaction expectations derived
// from edge-numbered transaction rules and a reference RAM image.
module tb_spi_sram_slave;

  logic        clk = 1'b0;
  logic        rst_n, en, cs_n, mosi;
  logic        miso;
  logic [23:0] mem_addr;
  logic        mem_en, mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  spi_sram_slave dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .mem_addr(mem_addr), .mem_en(mem_en), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // 4 KiB RAM aliased on the low 12 address bits
  logic [7:0] env_ram [0:4095];
  logic [7:0] ref_ram [0:4095];
  logic       load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 4096; i++) env_ram[i] <= ref_ram[i];
      mem_rdata <= 8'h00;
    end else if (mem_en) begin
      if (mem_wr) env_ram[mem_addr[11:0]] <= mem_wdata;
      else        mem_rdata <= env_ram[mem_addr[11:0]];
    end
  end

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          edge_no;
  int          obs_edge [$];
  logic        obs_wr   [$];
  logic [23:0] obs_addr [$];
  logic [7:0]  obs_data [$];
  logic        miso_obs [0:255];
  logic [7:0]  tx_data  [$];
  logic        m_rd;
  logic [23:0] m_addr;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic e, input logic c, input logic m);
    @(negedge clk);
    en = e; cs_n = c; mosi = m;
    @(posedge clk);
    #1;
    if (e && !c) edge_no++;
    if (mem_en) begin
      obs_edge.push_back(edge_no);
      obs_wr.push_back(mem_wr);
      obs_addr.push_back(mem_addr);
      obs_data.push_back(mem_wdata);
    end
    if (e && !c && edge_no < 256) miso_obs[edge_no] = miso;
  endtask

  function automatic logic exp_miso(input int e);
    int j;
    logic [23:0] a;
    logic [7:0]  b;
    if (!m_rd || e < 34) return 1'b0;
    j = e - 34;
    a = m_addr + 24'(j / 8);
    b = ref_ram[a[11:0]];
    return b[7 - (j % 8)];
  endfunction

  task automatic clear_obs();
    obs_edge.delete(); obs_wr.delete(); obs_addr.delete(); obs_data.delete();
    edge_no = 0;
  endtask

  task automatic run_txn(input logic [7:0] cmd, input logic [23:0] a, input int n,
                         input int gap_at, input int gap_len, input bit rnd_gaps,
                         input int rst_at);
    logic        bits [$];
    logic        valid;
    int          last, g, ne;
    int          e_edge [$];
    logic        e_wr   [$];
    logic [23:0] e_addr [$];
    logic [7:0]  e_data [$];
    logic [7:0]  dat;
    for (int i = 7; i >= 0; i--) bits.push_back(cmd[i]);
    for (int i = 23; i >= 0; i--) bits.push_back(a[i]);
    foreach (tx_data[k]) for (int i = 7; i >= 0; i--) bits.push_back(tx_data[k][i]);
    while (bits.size() < n) bits.push_back(1'($urandom));
    valid  = (cmd[6:0] == 7'h03) || (cmd[6:0] == 7'h02);
    m_rd   = (cmd[6:0] == 7'h03);
    m_addr = a;
    last   = (rst_at > 0) ? rst_at : n;

    clear_obs();
    tick(1'b1, 1'b1, 1'($urandom));
    check("idle_miso", 48'(miso), 48'(0));
    for (int i = 1; i <= n; i++) begin
      g = (i == gap_at) ? gap_len :
          (rnd_gaps && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      for (int r = 0; r < g; r++) begin
        tick(1'b0, 1'($urandom), 1'($urandom));
        check("frozen_miso", 48'(miso), 48'(exp_miso(i - 1)));
      end
      tick(1'b1, 1'b0, bits[i-1]);
      if (i == rst_at) begin
        #2 rst_n = 1'b0;
        cs_n = 1'b0;
        #1;
        check("abort_outs", {miso, mem_en, mem_wr, mem_addr, mem_wdata, 13'h0}, 48'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
    end
    if (rst_at == 0) begin
      tick(1'b1, 1'b1, 1'b0);
      check("close_miso", 48'(miso), 48'(0));
      tick(1'b1, 1'b1, 1'b0);
    end

    if (valid) begin
      for (int k = 0; (m_rd ? 32 : 40) + 8 * k <= last; k++) begin
        e_edge.push_back((m_rd ? 32 : 40) + 8 * k);
        e_wr.push_back(!m_rd);
        e_addr.push_back(a + 24'(k));
        dat = '0;
        if (!m_rd) for (int b = 0; b < 8; b++) dat = {dat[6:0], bits[32 + 8 * k + b]};
        e_data.push_back(dat);
      end
    end
    check("strobe_count", 48'(obs_edge.size()), 48'(e_edge.size()));
    ne = (obs_edge.size() < e_edge.size()) ? obs_edge.size() : e_edge.size();
    for (int k = 0; k < ne; k++) begin
      check("strobe_edge", 48'(obs_edge[k]), 48'(e_edge[k]));
      check("strobe_wr",   48'(obs_wr[k]),   48'(e_wr[k]));
      check("strobe_addr", 48'(obs_addr[k]), 48'(e_addr[k]));
      if (e_wr[k]) check("strobe_data", 48'(obs_data[k]), 48'(e_data[k]));
    end
    for (int e = 1; e <= last && e < 256; e++)
      check($sformatf("miso_e%0d", e), 48'(miso_obs[e]), 48'(exp_miso(e)));
    for (int k = 0; k < e_edge.size(); k++)
      if (e_wr[k]) ref_ram[e_addr[k][11:0]] = e_data[k];
    tx_data.delete();
  endtask

  initial begin
    logic [7:0]  rc;
    logic [23:0] ra;
    logic [39:0] bits40;
    rst_n = 1'b0; en = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    for (int i = 0; i < 4096; i++) ref_ram[i] = 8'($urandom);
    ref_ram[12'h407] = 8'h77; ref_ram[12'h408] = 8'h88; ref_ram[12'h409] = 8'h99;
    ref_ram[12'h40A] = 8'hAA; ref_ram[12'h40B] = 8'hBB; ref_ram[12'h40C] = 8'hCC;
    load_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_miso",  48'(miso),      48'(0));
    check("rst_en",    48'(mem_en),    48'(0));
    check("rst_wr",    48'(mem_wr),    48'(0));
    check("rst_addr",  48'(mem_addr),  48'(0));
    check("rst_wdata", 48'(mem_wdata), 48'(0));
    @(negedge clk);
    load_req = 1'b0;
    rst_n = 1'b1;

    run_txn(8'h83, 24'h800409, 64, 0, 0, 1'b0, 0);
    tx_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_txn(8'h82, 24'h800405, 64, 0, 0, 1'b0, 0);
    run_txn(8'h83, 24'h800405, 74, 0, 0, 1'b0, 0);
    tx_data = '{8'h5A, 8'hA5};
    run_txn(8'h02, 24'hFFFFFF, 51, 0, 0, 1'b0, 0);
    run_txn(8'h03, 24'hFFFFFF, 58, 0, 0, 1'b0, 0);
    run_txn(8'h05, 24'h000100, 88, 0, 0, 1'b0, 0);
    tx_data = '{8'hDE, 8'hAD};
    run_txn(8'h82, 24'h123456, 48, 20, 5, 1'b0, 0);
    run_txn(8'h03, 24'h123456, 50, 0, 0, 1'b1, 0);

    // abort mid-read, then confirm no start without a fresh cs_n high
    run_txn(8'h83, 24'h800405, 60, 0, 0, 1'b0, 45);
    clear_obs();
    bits40 = {8'h02, 24'h000100, 8'hAB};
    for (int i = 39; i >= 0; i--) tick(1'b1, 1'b0, bits40[i]);
    check("unarmed_strobes", 48'(obs_edge.size()), 48'(0));
    check("unarmed_miso", 48'(miso), 48'(0));
    run_txn(8'h83, 24'h800407, 60, 0, 0, 1'b0, 0);

    for (int t = 0; t < 20; t++) begin
      case ($urandom_range(0, 4))
        0: rc = 8'h02;
        1: rc = 8'h03;
        2: rc = 8'h82;
        3: rc = 8'h83;
        default: rc = 8'($urandom);
      endcase
      ra = ($urandom_range(0, 3) == 0) ? 24'hFFFFF8 + 24'($urandom_range(0, 7)) : 24'($urandom);
      run_txn(rc, ra, int'($urandom_range(1, 110)), 0, 0, 1'b1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
